// File: rtl/fifo_pkg.sv
// Shared helpers for the sync_fifo_v2 family.
// Derives the count width and checks depth legality at elaboration.
package fifo_pkg;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Parametrised single-clock FIFO with thresholds, occupancy count,
// sticky error flags and selectable first-word-fall-through read.
module sync_fifo_v2
    import fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0,
    parameter int CNT_W  = fifo_cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    input  logic [CNT_W-1:0]  i_alm_full_thr,
    input  logic [CNT_W-1:0]  i_alm_empty_thr,
    input  logic              i_clr_err,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int AW = $clog2(DEPTH);

    if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_v2: DEPTH must be a power of two >= 4");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic              rdvalid_q, rdvalid_d;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_acc;
    logic              rd_acc;

    // Acceptance uses registered flags only, so full+rd frees a slot next cycle.
    always_comb begin
        wr_acc    = i_wren && !full_q;
        rd_acc    = i_rden && !empty_q;
        wr_ptr_d  = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + AW'(rd_acc);
        count_d   = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        full_d    = (count_d == CNT_W'(DEPTH));
        empty_d   = (count_d == '0);
        afull_d   = (count_d >= i_alm_full_thr);
        aempty_d  = (count_d <= i_alm_empty_thr);
        ovf_d     = (i_wren && full_q) || (ovf_q && !i_clr_err);
        unf_d     = (i_rden && empty_q) || (unf_q && !i_clr_err);
        rdvalid_d = rd_acc;
        rddata_d  = rd_acc ? mem_rdata : rddata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rddata_q  <= rddata_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_wrdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // FWFT shows the head word directly; gated to zero so reset reads as 0.
    if (FWFT != 0) begin : g_fwft
        assign o_rddata  = empty_q ? '0 : mem_rdata;
        assign o_rdvalid = !empty_q;
    end else begin : g_reg
        assign o_rddata  = rddata_q;
        assign o_rdvalid = rdvalid_q;
    end

    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_alm_full  = afull_q;
    assign o_alm_empty = aempty_q;
    assign o_count     = count_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
